// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester RAM arbiter: FSM encoding,
// default widths and requester identifiers.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 32;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input picker: round-robin (or D-wins-ties when FIXED_PRI != 0) with a
// last_grant register that only advances when a request is accepted.
module rr_arb2
  import mem_arb_pkg::*;
#(
  parameter int FIXED_PRI = 0
) (
  input  logic clock,
  input  logic clear,
  input  logic en,
  input  logic req_if,
  input  logic req_d,
  output logic any,
  output logic winner
);

  logic last_grant;

  always_comb begin
    any    = req_if | req_d;
    winner = REQ_IF;
    if (req_if && req_d) begin
      // The requester that did not win last time takes the tie.
      winner = (FIXED_PRI != 0) ? REQ_D : ~last_grant;
    end else if (req_d) begin
      winner = REQ_D;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      last_grant <= REQ_IF;
    end else if (en && any) begin
      last_grant <= winner;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port RAM between instruction fetch (IF) and the data
// port (D); every output is registered and only one RAM strobe is ever high.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FIXED_PRI = 0
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state_q, state_nxt;
  logic   win_p0, win_nxt;
  logic   we_p0, we_nxt;
  logic   arb_en, arb_any, arb_win;

  logic              if_gnt_nxt, d_gnt_nxt, if_rvalid_nxt, d_rvalid_nxt;
  logic              mem_read_nxt, mem_write_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt, if_rdata_nxt, d_rdata_nxt;

  assign arb_en = (state_q == IDLE);

  rr_arb2 #(
    .FIXED_PRI(FIXED_PRI)
  ) u_arb (
    .clock (clock),
    .clear (clear),
    .en    (arb_en),
    .req_if(if_req),
    .req_d (d_req),
    .any   (arb_any),
    .winner(arb_win)
  );

  always_comb begin
    state_nxt     = state_q;
    win_nxt       = win_p0;
    we_nxt        = we_p0;
    if_gnt_nxt    = 1'b0;
    d_gnt_nxt     = 1'b0;
    if_rvalid_nxt = 1'b0;
    d_rvalid_nxt  = 1'b0;
    mem_read_nxt  = 1'b0;
    mem_write_nxt = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_rdata_nxt  = if_rdata;
    d_rdata_nxt   = d_rdata;
    case (state_q)
      // Accept: latch winner and set up the RAM strobes for the next cycle.
      IDLE: begin
        if (arb_any) begin
          win_nxt       = arb_win;
          we_nxt        = (arb_win == REQ_D) && d_we;
          mem_addr_nxt  = (arb_win == REQ_D) ? d_addr : if_addr;
          if (arb_win == REQ_D) begin
            mem_wdata_nxt = d_wdata;
          end
          mem_read_nxt  = ~we_nxt;
          mem_write_nxt = we_nxt;
          if_gnt_nxt    = (arb_win == REQ_IF);
          d_gnt_nxt     = (arb_win == REQ_D);
          state_nxt     = ACCESS;
        end
      end
      // RAM sees the strobe this cycle; writes are done after it.
      ACCESS: begin
        state_nxt = we_p0 ? IDLE : CAPTURE;
      end
      // Registered RAM data is valid now.
      CAPTURE: begin
        if (win_p0 == REQ_D) begin
          d_rdata_nxt  = mem_rdata;
          d_rvalid_nxt = 1'b1;
        end else begin
          if_rdata_nxt  = mem_rdata;
          if_rvalid_nxt = 1'b1;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q   <= IDLE;
      win_p0    <= REQ_IF;
      we_p0     <= 1'b0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state_q   <= state_nxt;
      win_p0    <= win_nxt;
      we_p0     <= we_nxt;
      if_gnt    <= if_gnt_nxt;
      d_gnt     <= d_gnt_nxt;
      if_rvalid <= if_rvalid_nxt;
      d_rvalid  <= d_rvalid_nxt;
      mem_read  <= mem_read_nxt;
      mem_write <= mem_write_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      if_rdata  <= if_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, request drivers and a negedge scoreboard
// monitor; a second instance covers the fixed-priority variant.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [8:0]  if_addr = '0, d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_read, mem_write;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [8:0]  mem_addr;

  logic        fp_if_req = 1'b0, fp_d_req = 1'b0;
  logic [8:0]  fp_if_addr = '0, fp_d_addr = '0;
  logic        fp_if_gnt, fp_if_rvalid, fp_d_gnt, fp_d_rvalid, fp_mem_read, fp_mem_write;
  logic [31:0] fp_if_rdata, fp_d_rdata, fp_mem_wdata, fp_mem_rdata;
  logic [8:0]  fp_mem_addr;

  logic [31:0] ram    [0:511];
  logic [31:0] fp_ram [0:511];
  logic [31:0] model  [0:511];

  typedef struct {
    logic [31:0] data;
    int          issue;
    int          lat;
  } exp_t;

  exp_t exp_if_q[$];
  exp_t exp_d_q[$];
  logic gnt_q[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int if_issue = 0, if_glat = -1, d_issue = 0, d_glat = -1;

  mem_arbiter #(.ADDR_W(9), .DATA_W(32), .FIXED_PRI(0)) dut (
    .clock(clock), .clear(clear),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(9), .DATA_W(32), .FIXED_PRI(1)) dut_fp (
    .clock(clock), .clear(clear),
    .if_req(fp_if_req), .if_addr(fp_if_addr), .if_gnt(fp_if_gnt),
    .if_rvalid(fp_if_rvalid), .if_rdata(fp_if_rdata),
    .d_req(fp_d_req), .d_we(1'b0), .d_addr(fp_d_addr), .d_wdata(32'h0),
    .d_gnt(fp_d_gnt), .d_rvalid(fp_d_rvalid), .d_rdata(fp_d_rdata),
    .mem_read(fp_mem_read), .mem_write(fp_mem_write), .mem_addr(fp_mem_addr),
    .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  function automatic logic [31:0] init_word(input int i);
    if (i == 0)  return 32'h0900_0069;
    if (i == 71) return 32'h0000_0094;
    return 32'h1000_0000 + 32'(i * 7);
  endfunction

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i]    <= init_word(i);
      fp_ram[i] <= init_word(i);
      model[i]  =  init_word(i);
    end
  end

  // Single-port RAM: write beats read, read data registered.
  always @(posedge clock) begin
    if (mem_write) ram[mem_addr] <= mem_wdata;
    else if (mem_read) mem_rdata <= ram[mem_addr];
    if (fp_mem_write) fp_ram[fp_mem_addr] <= fp_mem_wdata;
    else if (fp_mem_read) fp_mem_rdata <= fp_ram[fp_mem_addr];
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk1({nm, "_if_gnt"}, if_gnt, 1'b0);
    chk1({nm, "_d_gnt"}, d_gnt, 1'b0);
    chk1({nm, "_if_rvalid"}, if_rvalid, 1'b0);
    chk1({nm, "_d_rvalid"}, d_rvalid, 1'b0);
    chk1({nm, "_mem_read"}, mem_read, 1'b0);
    chk1({nm, "_mem_write"}, mem_write, 1'b0);
    chk32({nm, "_mem_addr"}, 32'(mem_addr), 32'h0);
    chk32({nm, "_mem_wdata"}, mem_wdata, 32'h0);
    chk32({nm, "_if_rdata"}, if_rdata, 32'h0);
    chk32({nm, "_d_rdata"}, d_rdata, 32'h0);
  endtask

  task automatic if_read(input logic [8:0] a, input int glat, input int rlat);
    int n;
    @(posedge clock); #1;
    if_addr = a; if_req = 1'b1; if_issue = cyc; if_glat = glat;
    exp_if_q.push_back('{data: model[a], issue: cyc, lat: rlat});
    n = 0;
    do begin @(negedge clock); n++; end while (!if_gnt && n < 200);
    if (!if_gnt) begin
      checks++; errors++;
      $display("FAIL if_gnt_timeout addr=%0d", a);
    end
    @(posedge clock); #1;
    if_req = 1'b0;
  endtask

  task automatic d_op(input logic we, input logic [8:0] a, input logic [31:0] w,
                      input int glat, input int rlat);
    int n;
    @(posedge clock); #1;
    d_we = we; d_addr = a; d_wdata = w; d_req = 1'b1; d_issue = cyc; d_glat = glat;
    if (we) model[a] = w;
    else exp_d_q.push_back('{data: model[a], issue: cyc, lat: rlat});
    n = 0;
    do begin @(negedge clock); n++; end while (!d_gnt && n < 200);
    if (!d_gnt) begin
      checks++; errors++;
      $display("FAIL d_gnt_timeout addr=%0d", a);
    end
    @(posedge clock); #1;
    d_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    clear = 1'b1;
    repeat (2) @(posedge clock);
    #1 clear = 1'b0;
  endtask

  // Scoreboard monitor, away from the active edge.
  always @(negedge clock) begin
    exp_t e;
    logic g;
    checks++;
    if ((mem_read && mem_write) || (if_gnt && d_gnt) || (if_rvalid && d_rvalid)) begin
      errors++;
      $display("FAIL exclusive rd=%b wr=%b ignt=%b dgnt=%b irv=%b drv=%b required=one-hot",
               mem_read, mem_write, if_gnt, d_gnt, if_rvalid, d_rvalid);
    end
    if (if_gnt) begin
      chk1("if_acc_read", mem_read, 1'b1);
      chk1("if_acc_write", mem_write, 1'b0);
      chk32("if_acc_addr", 32'(mem_addr), 32'(if_addr));
      if (if_glat >= 0) chk32("if_gnt_latency", 32'(cyc - if_issue), 32'(if_glat));
    end
    if (d_gnt) begin
      chk1("d_acc_read", mem_read, ~d_we);
      chk1("d_acc_write", mem_write, d_we);
      chk32("d_acc_addr", 32'(mem_addr), 32'(d_addr));
      if (d_we) chk32("d_acc_wdata", mem_wdata, d_wdata);
      if (d_glat >= 0) chk32("d_gnt_latency", 32'(cyc - d_issue), 32'(d_glat));
    end
    if ((if_gnt || d_gnt) && gnt_q.size() > 0) begin
      g = gnt_q.pop_front();
      chk1("gnt_order_is_d", d_gnt, g);
    end
    if (if_rvalid) begin
      if (exp_if_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL if_rvalid_unexpected actual=1 required=0");
      end else begin
        e = exp_if_q.pop_front();
        chk32("if_rdata", if_rdata, e.data);
        if (e.lat >= 0) chk32("if_rvalid_latency", 32'(cyc - e.issue), 32'(e.lat));
      end
    end
    if (d_rvalid) begin
      if (exp_d_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL d_rvalid_unexpected actual=1 required=0");
      end else begin
        e = exp_d_q.pop_front();
        chk32("d_rdata", d_rdata, e.data);
        if (e.lat >= 0) chk32("d_rvalid_latency", 32'(cyc - e.issue), 32'(e.lat));
      end
    end
  end

  initial begin
    int n, dg;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_all_zero("reset");
    #1 clear = 1'b0;

    // IF read after reset; D side must stay quiet.
    if_read(9'd0, 1, 3);
    repeat (3) @(negedge clock);
    chk32("d_rdata_untouched", d_rdata, 32'h0);
    chk32("if_rdata_first", if_rdata, 32'h0900_0069);

    // D write then read back.
    d_op(1'b1, 9'd142, 32'h0000_ABBA, 1, -1);
    d_op(1'b0, 9'd142, 32'h0, 1, 3);
    repeat (3) @(negedge clock);
    chk32("d_rdata_abba", d_rdata, 32'h0000_ABBA);
    chk32("if_rdata_held", if_rdata, 32'h0900_0069);

    // Clear during ACCESS of an IF read aborts it.
    @(posedge clock); #1;
    if_addr = 9'd5; if_req = 1'b1; if_issue = cyc; if_glat = 1;
    n = 0;
    do begin @(negedge clock); n++; end while (!if_gnt && n < 50);
    chk1("abort_gnt_seen", if_gnt, 1'b1);
    #1 clear = 1'b1; if_req = 1'b0;
    @(negedge clock);
    chk_all_zero("abort");
    @(posedge clock); #1 clear = 1'b0;
    repeat (5) @(negedge clock);
    if_read(9'd5, 1, 3);
    repeat (3) @(negedge clock);

    // Contention after reset: D first, then strict alternation.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      gnt_q.push_back(1'b1);
      gnt_q.push_back(1'b0);
    end
    fork
      begin
        d_op(1'b0, 9'd71, 32'h0, 1, 3);
        d_op(1'b0, 9'd72, 32'h0, -1, -1);
        d_op(1'b0, 9'd73, 32'h0, -1, -1);
      end
      begin
        if_read(9'd0, 4, 6);
        if_read(9'd1, -1, -1);
        if_read(9'd2, -1, -1);
      end
    join
    repeat (4) @(negedge clock);
    chk32("gnt_order_drained", 32'(gnt_q.size()), 32'h0);
    chk32("d_rdata_last", d_rdata, init_word(73));

    // Random mix: IF reads low half, D reads/writes high half.
    fork
      for (int i = 0; i < 12; i++)
        if_read(9'($urandom_range(0, 255)), -1, -1);
      for (int j = 0; j < 12; j++)
        d_op(1'($urandom_range(0, 1)), 9'(256 + $urandom_range(0, 255)), $urandom, -1, -1);
    join
    for (int k = 0; k < 4; k++)
      d_op(1'b0, 9'(300 + k), 32'h0, 1, 3);
    repeat (4) @(negedge clock);

    // Fixed priority: IF starves while D holds its request.
    @(posedge clock); #1;
    fp_if_addr = 9'd7; fp_d_addr = 9'd3; fp_if_req = 1'b1; fp_d_req = 1'b1;
    dg = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (fp_if_gnt) begin
        checks++; errors++;
        $display("FAIL fp_if_starve actual=gnt required=no_gnt cycle=%0d", i);
      end
      if (fp_d_gnt) dg++;
    end
    chk32("fp_d_gnt_count", 32'(dg), 32'd5);
    @(posedge clock); #1 fp_d_req = 1'b0;
    n = 0;
    do begin
      @(negedge clock); n++;
      if (fp_if_gnt) fp_if_req = 1'b0;
    end while (!fp_if_rvalid && n < 20);
    chk1("fp_if_rvalid_seen", fp_if_rvalid, 1'b1);
    chk32("fp_if_rdata", fp_if_rdata, init_word(7));
    chk32("fp_d_rdata", fp_d_rdata, init_word(3));

    chk32("if_queue_empty", 32'(exp_if_q.size()), 32'h0);
    chk32("d_queue_empty", 32'(exp_d_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
